// File: rtl/gabor_sym_conv_pipe.sv
// Three-stage symmetric-kernel Gabor convolution: per-level group sums, per-level products, sum/round/clamp.
// Optional feature macro GABOR_CONV_SAT_EN: clamp the result and flag sat; otherwise wrap with sat tied low.
module gabor_sym_conv_pipe #(
    parameter int KERNEL_SIZE = 5,
    parameter int N_LEVELS    = 5,
    parameter int PIX_W       = 9,
    parameter int COEFF_W     = 17,
    parameter int COEFF_FRAC  = 15,
    parameter int OUT_W       = 16,
    parameter int ROUND       = 1,
    localparam int NT         = KERNEL_SIZE * KERNEL_SIZE,
    localparam int ADDR_W     = $clog2(N_LEVELS + NT)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cfg_we,
    input  logic [ADDR_W-1:0]       cfg_addr,
    input  logic [COEFF_W-1:0]      cfg_data,
    output logic                    cfg_err,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NT*PIX_W-1:0]     pixels,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] result,
    output logic                    sat
);

    localparam int LVL_W = (N_LEVELS > 1) ? $clog2(N_LEVELS) : 1;
    localparam int GS_W  = PIX_W + $clog2(NT);
    localparam int PR_W  = GS_W + COEFF_W;
    localparam int LS_W  = PR_W + $clog2(N_LEVELS);
    // One guard bit so the rounding constant can never overflow the level sum.
    localparam int RS_W  = LS_W + 1;
    localparam logic signed [RS_W-1:0] RND_C =
        (ROUND != 0) ? (RS_W'(1) <<< (COEFF_FRAC - 1)) : '0;

    logic signed [COEFF_W-1:0] coeff    [N_LEVELS];
    logic        [LVL_W-1:0]   tap_lvl  [NT];

    logic signed [PIX_W-1:0]   tap_px   [NT];
    logic signed [GS_W-1:0]    gsum_d   [N_LEVELS];
    logic signed [GS_W-1:0]    gsum_q   [N_LEVELS];
    logic signed [COEFF_W-1:0] s1_coeff [N_LEVELS];
    logic signed [PR_W-1:0]    prod     [N_LEVELS];
    logic                      v1;
    logic                      v2;

    logic signed [RS_W-1:0]    acc;
    logic signed [OUT_W-1:0]   res_d;
    logic                      sat_d;

    logic en;
    logic accept;
    logic busy;
    logic is_coef;
    logic addr_ok;
    logic lvl_ok;
    logic cfg_bad;
    logic [LVL_W-1:0] lvl_val;

    assign en       = !out_valid || out_ready;
    assign in_ready = en;
    assign accept   = in_valid && en;

    // Configuration write port; writes are only legal with the whole pipeline empty.
    assign busy    = v1 || v2 || out_valid;
    assign lvl_val = cfg_data[LVL_W-1:0];
    assign is_coef = int'(cfg_addr) < N_LEVELS;
    assign addr_ok = int'(cfg_addr) < (N_LEVELS + NT);
    assign lvl_ok  = int'(lvl_val) < N_LEVELS;
    assign cfg_bad = busy || !addr_ok || (!is_coef && !lvl_ok);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_err <= 1'b0;
            for (int unsigned l = 0; l < N_LEVELS; l++) coeff[l] <= '0;
            for (int unsigned t = 0; t < NT; t++) tap_lvl[t] <= '0;
        end else begin
            cfg_err <= cfg_we && cfg_bad;
            if (cfg_we && !cfg_bad) begin
                for (int unsigned l = 0; l < N_LEVELS; l++)
                    if (cfg_addr == ADDR_W'(l)) coeff[l] <= cfg_data;
                for (int unsigned t = 0; t < NT; t++)
                    if (cfg_addr == ADDR_W'(N_LEVELS + t)) tap_lvl[t] <= lvl_val;
            end
        end
    end

    // S1: sum the taps belonging to each symmetry level.
    always_comb begin
        for (int unsigned t = 0; t < NT; t++) tap_px[t] = pixels[t*PIX_W +: PIX_W];
        for (int unsigned l = 0; l < N_LEVELS; l++) begin
            gsum_d[l] = '0;
            for (int unsigned t = 0; t < NT; t++)
                if (tap_lvl[t] == LVL_W'(l)) gsum_d[l] = gsum_d[l] + GS_W'(tap_px[t]);
        end
    end

    // Coefficients are snapshotted with the group sums so a write landing on the
    // acceptance edge only affects later samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1 <= 1'b0;
            for (int unsigned l = 0; l < N_LEVELS; l++) begin
                gsum_q[l]   <= '0;
                s1_coeff[l] <= '0;
            end
        end else if (en) begin
            v1 <= accept;
            for (int unsigned l = 0; l < N_LEVELS; l++) begin
                gsum_q[l]   <= gsum_d[l];
                s1_coeff[l] <= coeff[l];
            end
        end
    end

    // S2: per-level products.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2 <= 1'b0;
            for (int unsigned l = 0; l < N_LEVELS; l++) prod[l] <= '0;
        end else if (en) begin
            v2 <= v1;
            for (int unsigned l = 0; l < N_LEVELS; l++)
                prod[l] <= PR_W'(gsum_q[l]) * PR_W'(s1_coeff[l]);
        end
    end

    // S3: level sum, optional round-half-up, arithmetic shift, clamp or wrap.
    always_comb begin
        acc = RND_C;
        for (int unsigned l = 0; l < N_LEVELS; l++) acc = acc + RS_W'(prod[l]);
    end

`ifdef GABOR_CONV_SAT_EN
    localparam logic signed [RS_W-1:0] MAX_V = RS_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
    localparam logic signed [RS_W-1:0] MIN_V = ~MAX_V;
    logic signed [RS_W-1:0] acc_sh;

    always_comb begin
        acc_sh = acc >>> COEFF_FRAC;
        sat_d  = 1'b0;
        res_d  = acc_sh[OUT_W-1:0];
        if (acc_sh > MAX_V) begin
            res_d = MAX_V[OUT_W-1:0];
            sat_d = 1'b1;
        end else if (acc_sh < MIN_V) begin
            res_d = MIN_V[OUT_W-1:0];
            sat_d = 1'b1;
        end
    end
`else
    always_comb begin
        res_d = OUT_W'(acc >>> COEFF_FRAC);
        sat_d = 1'b0;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            result    <= '0;
            sat       <= 1'b0;
        end else if (en) begin
            out_valid <= v2;
            result    <= res_d;
            sat       <= sat_d;
        end
    end

endmodule

// File: tb/tb_gabor_sym_conv_pipe.sv
// Bench for gabor_sym_conv_pipe: directed corner cases plus random traffic scored against
// a tap-by-tap arithmetic model; a round-half-up and a floor instance share the stimulus.
module tb_gabor_sym_conv_pipe;

    localparam int NL     = 5;
    localparam int NT     = 25;
    localparam int PIX_W  = 9;
    localparam int CW     = 17;
    localparam int CF     = 15;
    localparam int OW     = 12;
    localparam int ADDR_W = 5;
    localparam int LVL_W  = 3;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 cfg_we;
    logic [ADDR_W-1:0]    cfg_addr;
    logic [CW-1:0]        cfg_data;
    logic                 in_valid;
    logic                 out_ready;
    logic [NT*PIX_W-1:0]  pixels;

    logic                 cfg_err, in_ready, out_valid, sat;
    logic signed [OW-1:0] result;
    logic                 cfg_err_f, in_ready_f, out_valid_f, sat_f;
    logic signed [OW-1:0] result_f;

    always #5 clk = ~clk;

    gabor_sym_conv_pipe #(.OUT_W(OW), .ROUND(1)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .cfg_err(cfg_err), .in_valid(in_valid), .in_ready(in_ready), .pixels(pixels),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .sat(sat)
    );

    gabor_sym_conv_pipe #(.OUT_W(OW), .ROUND(0)) dut_fl (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .cfg_err(cfg_err_f), .in_valid(in_valid), .in_ready(in_ready_f), .pixels(pixels),
        .out_valid(out_valid_f), .out_ready(out_ready), .result(result_f), .sat(sat_f)
    );

    typedef struct {
        longint r;
        bit     s;
        longint f;
        bit     fs;
    } exp_t;

    int     n_checks = 0;
    int     n_pass   = 0;
    exp_t   sb[$];
    int     m_coeff[NL];
    int     m_lvl[NT];
    int     pix[NT];
    bit     pend_err = 0;
    bit     hold_chk = 0;
    longint hold_r;
    bit     hold_s;
    bit     last_ov, last_ir, last_cerr, last_acc;
    longint last_r, last_f;
    bit     last_s;
    int     n_out = 0;
    int     n_acc = 0;

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    function automatic longint model_acc();
        longint a = 0;
        for (int t = 0; t < NT; t++) a += longint'(pix[t]) * longint'(m_coeff[m_lvl[t]]);
        return a;
    endfunction

    function automatic void model_fmt(input longint a, input bit rnd, output longint r, output bit s);
        longint v;
        longint hi = (longint'(1) <<< (OW - 1)) - 1;
        longint lo = -(longint'(1) <<< (OW - 1));
        v = (a + (rnd ? (longint'(1) <<< (CF - 1)) : longint'(0))) >>> CF;
        s = 1'b0;
`ifdef GABOR_CONV_SAT_EN
        if (v > hi) begin r = hi; s = 1'b1; end
        else if (v < lo) begin r = lo; s = 1'b1; end
        else r = v;
`else
        r = v & ((longint'(1) <<< OW) - 1);
        if (r > hi) r -= (longint'(1) <<< OW);
`endif
    endfunction

    task automatic pack();
        for (int t = 0; t < NT; t++) pixels[t*PIX_W +: PIX_W] = pix[t][PIX_W-1:0];
    endtask

    task automatic rand_pix();
        for (int t = 0; t < NT; t++)
            pix[t] = int'($urandom_range(0, (1 << PIX_W) - 1)) - (1 << (PIX_W - 1));
        pack();
    endtask

    // One clock: observe away from the edge, update the model, then wait for the next negedge.
    task automatic tick();
        bit     busy, acc_now, bad;
        exp_t   e;
        longint a;
        int     adr, lvl;
        #1;
        last_ov = out_valid; last_ir = in_ready; last_cerr = cfg_err; last_acc = 0;
        if (rst) begin
            check_eq("rst_out_valid", out_valid, 0);
            check_eq("rst_result", result, 0);
            check_eq("rst_cfg_err", cfg_err, 0);
            sb.delete();
            m_coeff = '{default: 0};
            m_lvl   = '{default: 0};
            pend_err = 0;
            hold_chk = 0;
            @(negedge clk);
            return;
        end
        busy = (sb.size() != 0);
        check_eq("cfg_err", cfg_err, pend_err);
        check_eq("in_ready", in_ready, !out_valid || out_ready);
        check_eq("in_ready_f", in_ready_f, !out_valid_f || out_ready);
        if (hold_chk) begin
            check_eq("hold_valid", out_valid, 1);
            check_eq("hold_result", result, hold_r);
            check_eq("hold_sat", sat, hold_s);
        end
        if (out_valid && out_ready) begin
            if (sb.size() == 0) check_eq("spurious_out", out_valid, 0);
            else begin
                e = sb.pop_front();
                check_eq("result", result, e.r);
                check_eq("sat", sat, e.s);
                check_eq("fl_valid", out_valid_f, 1);
                check_eq("fl_result", result_f, e.f);
                check_eq("fl_sat", sat_f, e.fs);
                last_r = result; last_s = sat; last_f = result_f;
                n_out++;
            end
        end
        hold_chk = out_valid && !out_ready;
        hold_r = result;
        hold_s = sat;
        acc_now = in_valid && in_ready;
        if (acc_now) begin
            a = model_acc();
            model_fmt(a, 1'b1, e.r, e.s);
            model_fmt(a, 1'b0, e.f, e.fs);
        end
        pend_err = 0;
        if (cfg_we) begin
            adr = int'(cfg_addr);
            lvl = int'(cfg_data) % (1 << LVL_W);
            bad = busy || (adr >= NL + NT) || (adr >= NL && lvl >= NL);
            if (!bad) begin
                if (adr < NL) m_coeff[adr] = int'($signed(cfg_data));
                else m_lvl[adr - NL] = lvl;
            end
            pend_err = bad;
        end
        if (acc_now) begin
            sb.push_back(e);
            last_acc = 1;
            n_acc++;
        end
        @(negedge clk);
    endtask

    task automatic cfg_write(input int adr, input logic [CW-1:0] d);
        cfg_we = 1'b1; cfg_addr = ADDR_W'(adr); cfg_data = d;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic send();
        pack();
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (last_acc) break;
        end
        check_eq("send_accepted", last_acc, 1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        in_valid  = 1'b0;
        for (int i = 0; i < 50 && sb.size() != 0; i++) tick();
        check_eq("drain_empty", sb.size(), 0);
    endtask

    task automatic rand_cfg();
        for (int l = 0; l < NL; l++) cfg_write(l, CW'($urandom()));
        for (int t = 0; t < NT; t++) cfg_write(NL + t, CW'($urandom_range(0, NL - 1)));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, n0;
        rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
        in_valid = 1'b0; out_ready = 1'b1; pixels = '0;
        pix = '{default: 0};
        @(negedge clk);
        tick();
        rst = 1'b0;
        tick();
        check_eq("rst_in_ready", last_ir, 1);
        check_eq("rst_sat", sat, 0);

        // Unit coefficient on every tap: sum of 25 tens, 3-cycle latency.
        cfg_write(0, CW'(32768));
        pix = '{default: 10};
        pack(); in_valid = 1'b1; tick(); in_valid = 1'b0;
        check_eq("acc_026", last_acc, 1);
        tick(); check_eq("lat1_026", last_ov, 0);
        tick(); check_eq("lat2_026", last_ov, 0);
        tick(); check_eq("lat3_026", last_ov, 1);
        check_eq("res_026", last_r, 250);
        check_eq("res_026_fl", last_f, 250);

        // Half-unit coefficient: rounding versus floor, both signs.
        cfg_write(0, CW'(16384));
        pix = '{default: 0}; pix[0] = 3;
        send(); drain();
        check_eq("res_027_pos", last_r, 2);
        check_eq("res_027_pos_fl", last_f, 1);
        pix[0] = -3;
        send(); drain();
        check_eq("res_027_neg", last_r, -1);
        check_eq("res_027_neg_fl", last_f, -2);

        // Large gain: clamp or wrap at 12 bits.
        cfg_write(0, CW'(65535));
        pix = '{default: 255};
        send(); drain();
`ifdef GABOR_CONV_SAT_EN
        check_eq("res_028", last_r, 2047);
        check_eq("sat_028", last_s, 1);
        check_eq("res_028_fl", last_f, 2047);
`else
        check_eq("res_028", last_r, 462);
        check_eq("sat_028", last_s, 0);
        check_eq("res_028_fl", last_f, 461);
`endif

        // Write coincident with acceptance into an empty pipe: old values for that sample.
        rand_cfg();
        rand_pix();
        cfg_we = 1'b1; cfg_addr = ADDR_W'(0); cfg_data = CW'(-20000);
        in_valid = 1'b1;
        tick();
        cfg_we = 1'b0; in_valid = 1'b0;
        check_eq("acc_021", last_acc, 1);
        drain();
        rand_pix(); send(); drain();

        // Output stall with four samples offered.
        rand_cfg();
        out_ready = 1'b0; k = 0; n0 = n_out;
        rand_pix();
        for (int i = 0; i < 5; i++) begin
            in_valid = (k < 4);
            tick();
            if (last_acc) begin k++; rand_pix(); end
        end
        check_eq("stall_in_ready", last_ir, 0);
        check_eq("stall_accepted", k, 3);
        out_ready = 1'b1;
        for (int i = 0; i < 20 && k < 4; i++) begin
            in_valid = 1'b1;
            tick();
            if (last_acc) begin k++; rand_pix(); end
        end
        in_valid = 1'b0;
        drain();
        check_eq("stall_delivered", n_out - n0, 4);

        // Rejected writes: busy pipeline, out-of-range address, illegal level.
        rand_pix(); send();
        cfg_write(0, CW'(12345));
        tick();
        check_eq("err_busy", last_cerr, 1);
        drain();
        rand_pix(); send(); drain();
        cfg_write(NL + NT, CW'(0));
        tick();
        check_eq("err_addr", last_cerr, 1);
        cfg_write(NL, CW'(7));
        tick();
        check_eq("err_level", last_cerr, 1);

        // Reset with two samples in flight.
        rand_cfg();
        in_valid = 1'b1;
        rand_pix(); tick();
        check_eq("rst_inflight_a", last_acc, 1);
        rand_pix(); tick();
        check_eq("rst_inflight_b", last_acc, 1);
        in_valid = 1'b0;
        rst = 1'b1; tick(); rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check_eq("post_rst_out_valid", last_ov, 0);
        end
        rand_cfg();
        rand_pix(); pack();
        in_valid = 1'b1; tick(); in_valid = 1'b0;
        check_eq("acc_031", last_acc, 1);
        tick(); check_eq("lat1_031", last_ov, 0);
        tick(); check_eq("lat2_031", last_ov, 0);
        tick(); check_eq("lat3_031", last_ov, 1);
        check_eq("sb_031", sb.size(), 0);

        // Random traffic with occasional (mostly rejected) config writes.
        rand_cfg();
        for (int i = 0; i < 400; i++) begin
            rand_pix();
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 9) < 7);
            cfg_we    = ($urandom_range(0, 9) == 0);
            cfg_addr  = ADDR_W'($urandom_range(0, 31));
            cfg_data  = CW'($urandom());
            tick();
        end
        cfg_we = 1'b0;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/gabor_sym_conv_pipe.md
GABOR_SYM_CONV_PIPE -- requirements
Module: gabor_sym_conv_pipe

Interface
REQ-001 The block SHALL have parameter KERNEL_SIZE, default 5, kernel edge; window = KERNEL_SIZE*KERNEL_SIZE taps (NT).
REQ-002 The block SHALL have parameter N_LEVELS, default 5, number of distinct coefficient levels (symmetry groups).
REQ-003 The block SHALL have parameter PIX_W, default 9, signed integer pixel width.
REQ-004 The block SHALL have parameter COEFF_W, default 17, signed coefficient width, and COEFF_FRAC, default 15, its fractional bits.
REQ-005 The block SHALL have parameter OUT_W, default 16, signed result width, and ROUND, default 1, round-half-up enable.
REQ-006 The block SHALL have port clk, input, 1, sole clock; all state on rising edge.
REQ-007 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-008 The block SHALL have ports cfg_we (input, 1), cfg_addr (input, clog2(N_LEVELS+NT)) and cfg_data (input, COEFF_W), forming the config write port.
REQ-009 The block SHALL have port cfg_err, output, 1, one-cycle pulse on a rejected write.
REQ-010 The block SHALL have ports in_valid (input, 1), in_ready (output, 1) and pixels (input, NT*PIX_W), with tap t at bits [t*PIX_W +: PIX_W].
REQ-011 The block SHALL have ports out_valid (output, 1), out_ready (input, 1), result (output, OUT_W, signed) and sat (output, 1, result was clamped).

Function
REQ-012 Config addresses 0..N_LEVELS-1 SHALL write coeff[addr]; addresses N_LEVELS..N_LEVELS+NT-1 SHALL write tap_lvl[addr-N_LEVELS] from cfg_data[clog2(N_LEVELS)-1:0].
REQ-013 A write while any pipeline stage holds valid data, to an out-of-range address, or with a level value >= N_LEVELS SHALL be ignored and SHALL pulse cfg_err the next cycle.
REQ-014 The pipeline SHALL have three stages: S1 forms per-level group sums of the taps mapped to that level; S2 forms group_sum*coeff per level; S3 sums the levels, rounds/shifts and saturates.
REQ-015 Internal widths SHALL be: group sum PIX_W+clog2(NT); product +COEFF_W; level sum +clog2(N_LEVELS). All arithmetic SHALL be signed, with no intermediate overflow.
REQ-016 With ROUND=1, S3 SHALL add 2^(COEFF_FRAC-1) and then arithmetic-shift right by COEFF_FRAC; with ROUND=0 it SHALL shift only (floor).
REQ-017 A sample SHALL be accepted when in_valid && in_ready; latency SHALL be 3 cycles from acceptance to out_valid with no stall.
REQ-018 The pipeline enable SHALL be en = !out_valid || out_ready; in_ready SHALL equal en; all stages SHALL hold when en=0.
REQ-019 result, sat and out_valid SHALL stay stable while out_valid && !out_ready.
REQ-020 Back-to-back acceptance SHALL sustain one result per cycle while out_ready=1, with output order equal to input order.
REQ-021 Simultaneous cfg_we and sample acceptance while the pipeline is empty SHALL apply the write; the accepted sample SHALL use the old values, and subsequent samples the new ones.

Reset
REQ-022 On rst, all stage valids, out_valid, sat, cfg_err, result, every coeff and every tap_lvl SHALL be cleared to 0; in_ready SHALL be 1 after reset release.
REQ-023 Reset asserted mid-operation SHALL discard all in-flight samples; no out_valid SHALL be produced for them.

Configuration
REQ-024 With macro GABOR_CONV_SAT_EN defined, S3 SHALL clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1] and set sat=1 on a clamped result.
REQ-025 Without GABOR_CONV_SAT_EN, result SHALL be the low OUT_W bits (wrap) and sat SHALL be tied to 0.

Verification
REQ-026 The bench SHALL cover: coeff[0]=32768, all tap_lvl=0, all pixels=10 -> result=250, out_valid exactly 3 cycles after acceptance.
REQ-027 The bench SHALL cover: coeff[0]=16384, tap0=3, others 0 -> result 2 (ROUND=1) / 1 (ROUND=0); tap0=-3 -> -1 (ROUND=1) / -2 (ROUND=0).
REQ-028 The bench SHALL cover: OUT_W=12, coeff[0]=65535, all pixels=255 -> 2047 and sat=1 with GABOR_CONV_SAT_EN; 462 and sat=0 without.
REQ-029 The bench SHALL cover: out_ready=0 for 5 cycles with 4 samples offered -> in_ready drops once out_valid=1, all 4 results delivered in order, none lost or duplicated.
REQ-030 The bench SHALL cover: cfg_we during an in-flight sample -> cfg_err pulse, coeff unchanged; cfg_addr=N_LEVELS+NT -> cfg_err pulse.
REQ-031 The bench SHALL cover: rst asserted with 2 samples in flight -> out_valid=0 and no results after release; a new sample yields a correct result 3 cycles after acceptance.
